// File: rtl/multiport_reg_file.sv
// multiport_reg_file: zero-initialised register file with NUM_READ read ports, two write ports and a busy scoreboard
// Ports:
//   clock, reset               rising-edge clock, asynchronous active-high reset
//   read_sel, read_data        packed per-port read indices and combinational read data
//   read_busy                  per-port busy flag of the selected register
//   wEn0/1, write_sel0/1,
//   write_data0/1              two write ports, port 1 wins on an index clash
//   reserve_en, reserve_sel    set the busy bit of one register
//   flush                      clear all busy bits
//   ready                      high once the initial zero-fill has finished
module multiport_reg_file #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_SEL_BITS   = 5,
    parameter int NUM_READ       = 3,
    parameter int BYPASS         = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_READ*REG_SEL_BITS-1:0]   read_sel,
    output logic [NUM_READ*REG_DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ-1:0]                read_busy,
    input  logic                               wEn0,
    input  logic                               wEn1,
    input  logic [REG_SEL_BITS-1:0]            write_sel0,
    input  logic [REG_SEL_BITS-1:0]            write_sel1,
    input  logic [REG_DATA_WIDTH-1:0]          write_data0,
    input  logic [REG_DATA_WIDTH-1:0]          write_data1,
    input  logic                               reserve_en,
    input  logic [REG_SEL_BITS-1:0]            reserve_sel,
    input  logic                               flush,
    output logic                               ready
);
    localparam int DEPTH = 1 << REG_SEL_BITS;

    typedef enum logic {INIT, RUN} state_t;

    state_t                    state, state_next;
    logic [REG_SEL_BITS-1:0]   cnt, cnt_next;
    logic [DEPTH-1:0]          busy, busy_next;
    logic [REG_DATA_WIDTH-1:0] mem [DEPTH];
    logic                      we0, we1;

    assign ready = state == RUN;
    assign we0   = ready && wEn0 && write_sel0 != '0;
    assign we1   = ready && wEn1 && write_sel1 != '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
            busy  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == INIT) begin
            cnt_next   = cnt + 1'b1;
            state_next = cnt == '1 ? RUN : INIT;
        end
    end

    // Write clears come first so a same-cycle reservation wins; flush overrides everything.
    always_comb begin
        busy_next = busy;
        if (ready) begin
            if (we0) busy_next[write_sel0] = 1'b0;
            if (we1) busy_next[write_sel1] = 1'b0;
            if (reserve_en && reserve_sel != '0) busy_next[reserve_sel] = 1'b1;
            if (flush) busy_next = '0;
        end
    end

    // No reset on the array: contents are rebuilt by the INIT sweep.
    always_ff @(posedge clock) begin
        if (!ready) begin
            mem[cnt] <= '0;
        end else begin
            if (we0) mem[write_sel0] <= write_data0;
            if (we1) mem[write_sel1] <= write_data1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_READ; k++) begin : g_rd
            logic [REG_SEL_BITS-1:0] sel;
            logic                    hit0, hit1;
            assign sel  = read_sel[k*REG_SEL_BITS +: REG_SEL_BITS];
            assign hit0 = BYPASS != 0 && we0 && write_sel0 == sel;
            assign hit1 = BYPASS != 0 && we1 && write_sel1 == sel;
            assign read_data[k*REG_DATA_WIDTH +: REG_DATA_WIDTH] =
                (!ready || sel == '0) ? '0 : hit1 ? write_data1 : hit0 ? write_data0 : mem[sel];
            assign read_busy[k] = ready && sel != '0 && busy[sel] && !hit0 && !hit1;
        end
    endgenerate
endmodule

// File: tb/tb_multiport_reg_file.sv
// tb_multiport_reg_file: directed self-checking bench for multiport_reg_file
module tb_multiport_reg_file;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] read_sel;
    logic [95:0] read_data;
    logic [2:0]  read_busy;
    logic        wEn0 = 1'b0, wEn1 = 1'b0;
    logic [4:0]  write_sel0 = '0, write_sel1 = '0;
    logic [31:0] write_data0 = '0, write_data1 = '0;
    logic        reserve_en = 1'b0;
    logic [4:0]  reserve_sel = '0;
    logic        flush = 1'b0;
    logic        ready;
    logic [4:0]  rs [3] = '{5'd0, 5'd0, 5'd0};
    int          total = 0;
    int          bad = 0;

    assign read_sel = {rs[2], rs[1], rs[0]};

    multiport_reg_file dut (
        .clock(clock), .reset(reset), .read_sel(read_sel), .read_data(read_data),
        .read_busy(read_busy), .wEn0(wEn0), .wEn1(wEn1), .write_sel0(write_sel0),
        .write_sel1(write_sel1), .write_data0(write_data0), .write_data1(write_data1),
        .reserve_en(reserve_en), .reserve_sel(reserve_sel), .flush(flush), .ready(ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rd(input int k);
        return read_data[k*32 +: 32];
    endfunction

    task automatic init_count(input string tag, input bit poke);
        int n = 0;
        while (!ready && n < 100) begin
            if (poke) begin
                wEn0 = 1'b1; write_sel0 = 5'd5; write_data0 = 32'h123;
                reserve_en = 1'b1; reserve_sel = 5'd9; flush = 1'b0;
            end
            step();
            n++;
        end
        wEn0 = 1'b0; reserve_en = 1'b0;
        #1;
        check(tag, 64'(n), 64'd32);
    endtask

    initial begin
        logic [31:0] acc;
        step();
        step();
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_data", 64'(read_data), 64'd0);
        check("reset_busy", 64'(read_busy), 64'd0);
        #2 reset = 1'b0;
        init_count("init_len", 1'b0);
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            rs[i % 3] = 5'(i);
            #1 acc |= rd(i % 3);
        end
        check("init_zero", 64'(acc), 64'd0);
        check("ready_run", 64'(ready), 64'd1);

        rs[0] = 5'd5; wEn0 = 1'b1; write_sel0 = 5'd5; write_data0 = 32'hDEADBEEF;
        #1 check("byp_w0", 64'(rd(0)), 64'hDEADBEEF);
        step(); wEn0 = 1'b0;
        #1 check("arr_w0", 64'(rd(0)), 64'hDEADBEEF);

        rs[1] = 5'd7;
        wEn0 = 1'b1; write_sel0 = 5'd7; write_data0 = 32'h11;
        wEn1 = 1'b1; write_sel1 = 5'd7; write_data1 = 32'h22;
        #1 check("byp_dual", 64'(rd(1)), 64'h22);
        step(); wEn0 = 1'b0; wEn1 = 1'b0;
        #1 check("arr_dual", 64'(rd(1)), 64'h22);

        rs[2] = 5'd9; reserve_en = 1'b1; reserve_sel = 5'd9;
        #1 check("rsv_same_cyc", 64'(read_busy[2]), 64'd0);
        step(); reserve_en = 1'b0;
        #1 check("rsv_set", 64'(read_busy[2]), 64'd1);
        wEn0 = 1'b1; write_sel0 = 5'd9; write_data0 = 32'h55;
        #1 check("wr_byp_busy", 64'(read_busy[2]), 64'd0);
        check("wr_byp_data", 64'(rd(2)), 64'h55);
        step(); wEn0 = 1'b0;
        #1 check("wr_clr_busy", 64'(read_busy[2]), 64'd0);
        reserve_en = 1'b1; reserve_sel = 5'd9;
        wEn1 = 1'b1; write_sel1 = 5'd9; write_data1 = 32'h66;
        step(); reserve_en = 1'b0; wEn1 = 1'b0;
        #1 check("rsv_wins", 64'(read_busy[2]), 64'd1);
        check("rsv_wins_data", 64'(rd(2)), 64'h66);
        wEn1 = 1'b1; write_sel1 = 5'd9; write_data1 = 32'h77;
        #1 check("w1_byp_busy", 64'(read_busy[2]), 64'd0);
        step(); wEn1 = 1'b0;
        #1 check("w1_clr_busy", 64'(read_busy[2]), 64'd0);
        check("w1_data", 64'(rd(2)), 64'h77);

        rs[0] = 5'd0; wEn0 = 1'b1; write_sel0 = 5'd0; write_data0 = 32'hFFFF;
        reserve_en = 1'b1; reserve_sel = 5'd0;
        #1 check("zero_byp", 64'(rd(0)), 64'd0);
        step(); wEn0 = 1'b0; reserve_en = 1'b0;
        #1 check("zero_data", 64'(rd(0)), 64'd0);
        check("zero_busy", 64'(read_busy[0]), 64'd0);

        reserve_en = 1'b1;
        reserve_sel = 5'd3; step();
        reserve_sel = 5'd4; step();
        reserve_sel = 5'd6; step();
        reserve_en = 1'b0;
        rs[0] = 5'd3; rs[1] = 5'd4; rs[2] = 5'd6;
        #1 check("pre_flush", 64'(read_busy), 64'b111);
        flush = 1'b1; reserve_en = 1'b1; reserve_sel = 5'd8;
        wEn0 = 1'b1; write_sel0 = 5'd10; write_data0 = 32'hAB;
        step(); flush = 1'b0; reserve_en = 1'b0; wEn0 = 1'b0;
        #1 check("flush_346", 64'(read_busy), 64'b000);
        rs[0] = 5'd8; rs[1] = 5'd10;
        #1 check("flush_8", 64'(read_busy[0]), 64'd0);
        check("flush_write", 64'(rd(1)), 64'hAB);

        reserve_en = 1'b1; reserve_sel = 5'd12;
        step(); reserve_en = 1'b0;
        rs[0] = 5'd5; rs[1] = 5'd12;
        #1 check("pre_rst_busy", 64'(read_busy[1]), 64'd1);
        check("pre_rst_data", 64'(rd(0)), 64'hDEADBEEF);
        #1 reset = 1'b1;
        #1 check("arst_ready", 64'(ready), 64'd0);
        check("arst_data", 64'(read_data), 64'd0);
        check("arst_busy", 64'(read_busy), 64'd0);
        #1 reset = 1'b0;
        rs[2] = 5'd9;
        init_count("reinit_len", 1'b1);
        check("reinit_data", 64'(rd(0)), 64'd0);
        check("reinit_busy", 64'(read_busy), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multiport_reg_file.md
MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

Interface
REQ-001 The block SHALL have parameter REG_DATA_WIDTH, default 32, register data width in bits.
REQ-002 The block SHALL have parameter REG_SEL_BITS, default 5, register index width; depth is 2^REG_SEL_BITS.
REQ-003 The block SHALL have parameter NUM_READ, default 3, number of read ports.
REQ-004 The block SHALL have parameter BYPASS, default 1, where 1 forwards same-cycle writes to reads and 0 disables forwarding.
REQ-005 clock  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 read_sel  in  NUM_READ*REG_SEL_BITS  packed read indices; port k uses slice k.
REQ-008 read_data  out  NUM_READ*REG_DATA_WIDTH  packed read data; port k uses slice k.
REQ-009 read_busy  out  NUM_READ  per port: the selected register has an outstanding reservation.
REQ-010 wEn0, wEn1  in  1 each  write enables for write ports 0 and 1.
REQ-011 write_sel0, write_sel1  in  REG_SEL_BITS each  write indices.
REQ-012 write_data0, write_data1  in  REG_DATA_WIDTH each  write data.
REQ-013 reserve_en  in  1  set the busy bit of reserve_sel.
REQ-014 reserve_sel  in  REG_SEL_BITS  index to reserve.
REQ-015 flush  in  1  clear all busy bits.
REQ-016 ready  out  1  initialisation complete; accesses are accepted.

Function
REQ-017 The block SHALL implement a two-state FSM: INIT, then RUN.
- In INIT, it writes 0 to entry[cnt] and increments cnt each cycle.
- After the cycle that writes entry 2^REG_SEL_BITS-1, it moves to RUN; INIT lasts exactly 2^REG_SEL_BITS cycles.
- RUN is held until reset.
REQ-018 ready SHALL be 0 in INIT and 1 in RUN.
REQ-019 While ready=0, the block SHALL ignore wEn0, wEn1, reserve_en and flush, and drive all read_data and read_busy outputs to 0.
REQ-020 Register 0 SHALL always read 0; writes and reservations targeting index 0 SHALL be ignored.
REQ-021 In RUN, port p SHALL commit write_data_p to entry[write_sel_p] at the rising edge when wEn_p=1 and write_sel_p!=0.
REQ-022 When both write ports target the same nonzero index in one cycle, port 1 SHALL win.
REQ-023 read_data SHALL be combinational with zero-cycle latency:
- BYPASS=1: write port 1 value on an index match, else write port 0 value on an index match, else the array entry.
- BYPASS=0: always the array entry.
REQ-024 busy[r] SHALL be set at the edge when reserve_en=1 and reserve_sel=r!=0.
REQ-025 busy[r] SHALL be cleared at the edge when a write commits to r.
REQ-026 When a reservation and a write commit target the same r in one cycle, the reservation SHALL win and busy[r] SHALL end at 1.
REQ-027 flush=1 SHALL clear every busy bit at the edge and SHALL override any reserve in the same cycle; writes still commit.
REQ-028 read_busy[k] SHALL equal busy[read_sel_k], except it SHALL be 0 when BYPASS=1 and a committing write targets read_sel_k in that cycle.
REQ-029 read_busy for index 0 SHALL always be 0.

Reset
REQ-030 Asserting reset SHALL immediately, without waiting for a clock edge:
- force the FSM to INIT with cnt=0;
- clear all busy bits;
- drive ready=0, all read_data=0 and all read_busy=0.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL restart initialisation from entry 0 on the first rising edge after deassertion; the array contents are undefined until INIT completes.

Verification
REQ-032 Init: deassert reset -> ready=0 for exactly 32 cycles, then 1; every index reads 0x00000000.
REQ-033 Write/bypass: wEn0=1, sel0=5, data0=0xDEADBEEF, read_sel port0=5 in the same cycle -> read_data0=0xDEADBEEF that cycle (BYPASS=1); the next cycle reads 0xDEADBEEF from the array.
REQ-034 Dual-write conflict: wEn0/wEn1 both target index 7 with data0=0x11 and data1=0x22 -> the same-cycle bypass read and later reads of 7 both return 0x22.
REQ-035 Scoreboard: reserve index 9 -> read_busy=1 next cycle; write index 9 with 0x55 -> read_busy=0 in the write cycle via bypass and after the edge; reserve and write to 9 in the same cycle -> busy remains 1.
REQ-036 Zero register and flush: write 0xFFFF to index 0 -> still reads 0; reserve 3, 4 and 6, then assert flush together with reserve 8 -> all four indices read_busy=0.
REQ-037 Async reset mid-RUN: assert reset between clock edges -> ready, read_data and read_busy go to 0 without a clock edge; after release, the 32-cycle INIT repeats.
